round_sequencer: RTL and testbench
==================================

// Module: round_sequencer
// PURPOSE
// Sequences duck flights while top-level game FSM is in Game (state 2'b01): launches each duck,
// counts shots per duck, detects hit/miss, tallies hits per round, advances rounds, raises
// game_over on failed round. Sits between game-state control, trigger/hit detect and duck motion.
// game_over drives the control FSM's Button2 input (Game -> Done).
// PARAMETERS
// DUCKS_PER_ROUND  10   ducks launched per round (2..15)
// SHOTS_PER_DUCK   3    shots allowed per duck (1..3)
// PASS_HITS        6    minimum hits in round to advance (<= DUCKS_PER_ROUND)
// FALL_FRAMES      60   frame_ticks spent in FALL / ESCAPE before next duck
// TIMEOUT_FRAMES   300  frame_ticks in FLY before fly-away (only with macro)
// MAX_ROUND        99   round_num saturates here
// PORTS
// CLK            in   1  system clock
// RESET          in   1  synchronous, active-high reset
// state          in   2  game state from control FSM: 00 Start, 01 Game, 10 Done
// frame_tick     in   1  1-cycle pulse per video frame
// trigger        in   1  1-cycle pulse, debounced gun trigger
// hit            in   1  crosshair over duck; qualified only when trigger=1
// duck_launch    out  1  1-cycle pulse: motion block starts new duck
// duck_active    out  1  level: duck flying (FLY)
// duck_falling   out  1  level: shot duck falling (FALL)
// duck_flyaway   out  1  level: duck escaping (ESCAPE)
// shots_left     out  2  remaining shots for current duck
// hits_in_round  out  4  hits this round
// duck_index     out  4  current duck 0..DUCKS_PER_ROUND-1
// round_num      out  7  current round, 1-based; 0 when idle
// round_clear    out  1  1-cycle pulse on passed round
// game_over      out  1  level: round failed; held until RESET or state=00
// BEHAVIOUR
// - Reset: FSM=IDLE; all outputs 0; internal frame counter 0. Applies next edge, any state.
// - States: IDLE, LAUNCH, FLY, FALL, ESCAPE, TALLY, OVER. All outputs registered.
// - Any state: state==00 -> IDLE next cycle, counters/outputs cleared (same as reset).
// - IDLE: state==01 -> LAUNCH; round_num<=1, duck_index<=0, hits_in_round<=0.
// - LAUNCH (1 cycle): duck_launch=1, shots_left<=SHOTS_PER_DUCK, frame counter<=0 -> FLY.
// - FLY: trigger: shots_left decrements same edge.
//     hit=1 -> hits_in_round+1, -> FALL.  hit=0 & shots_left==1 -> ESCAPE.  else stay FLY.
//   trigger/hit ignored in every state except FLY.
// - FALL / ESCAPE: count frame_ticks; on FALL_FRAMES-th tick: if duck_index==DUCKS_PER_ROUND-1
//   -> TALLY, else duck_index+1 -> LAUNCH. shots_left holds its final value.
// - TALLY (1 cycle): hits_in_round>=PASS_HITS -> round_clear=1, round_num+1 (saturate MAX_ROUND),
//   duck_index<=0, hits_in_round<=0 -> LAUNCH; else -> OVER.
// - OVER: game_over=1, all other outputs frozen; exit only via RESET or state==00.
// - state==10 while not OVER: freeze in current state (no transitions, counters hold).
// - Latency: trigger edge to duck_falling/duck_flyaway = 1 cycle.
// CONFIGURATION
// FLYAWAY_TIMEOUT_EN defined: in FLY, frame counter counts frame_ticks; on TIMEOUT_FRAMES-th tick
//   -> ESCAPE (shots_left unchanged). Trigger in same cycle as timeout tick wins (hit -> FALL,
//   miss handled per FLY rules; last-shot miss -> ESCAPE).
// FLYAWAY_TIMEOUT_EN undefined: no FLY timeout; duck stays in FLY until hit or shots exhausted.
// TESTING
// 1. RESET, state=01 -> next cycle duck_launch 1-cycle pulse, round_num=1, then shots_left=3, duck_active=1.
// 2. FLY, trigger+hit=1 -> shots_left=2, hits_in_round=1, duck_falling=1; 60 frame_ticks later
//    duck_index=1, duck_launch pulse.
// 3. FLY, three triggers hit=0 -> shots_left 2,1,0; duck_flyaway=1 after third; hits_in_round unchanged.
// 4. 10 ducks, 6 hits -> round_clear pulse, round_num=2, hits_in_round=0, duck_index=0; repeat with
//    5 hits -> game_over=1, held for 1000 cycles; state=00 -> all outputs 0.
// 5. Macro defined: 300 frame_ticks no trigger -> duck_flyaway; trigger+hit on 300th tick -> FALL.
//    Macro undefined: 1000 frame_ticks no trigger -> still duck_active.
// 6. RESET asserted mid-FALL, and trigger pulses in LAUNCH/FALL/TALLY -> reset values next cycle;
//    ignored triggers change nothing.

Source files
------------

// File: rtl/round_sequencer.sv
// round_sequencer: launches ducks, counts shots and hits, advances rounds, raises game_over.
// Optional FLY fly-away timeout enabled by defining FLYAWAY_TIMEOUT_EN.
module round_sequencer #(
  parameter int DUCKS_PER_ROUND = 10,
  parameter int SHOTS_PER_DUCK  = 3,
  parameter int PASS_HITS       = 6,
  parameter int FALL_FRAMES     = 60,
  parameter int TIMEOUT_FRAMES  = 300,
  parameter int MAX_ROUND       = 99
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] state,
  input  logic       frame_tick,
  input  logic       trigger,
  input  logic       hit,
  output logic       duck_launch,
  output logic       duck_active,
  output logic       duck_falling,
  output logic       duck_flyaway,
  output logic [1:0] shots_left,
  output logic [3:0] hits_in_round,
  output logic [3:0] duck_index,
  output logic [6:0] round_num,
  output logic       round_clear,
  output logic       game_over
);
  localparam int CW = $clog2((FALL_FRAMES > TIMEOUT_FRAMES ? FALL_FRAMES : TIMEOUT_FRAMES) + 1);
  localparam logic [CW-1:0] FALL_LAST = CW'(FALL_FRAMES - 1);
  localparam logic [3:0] LAST_DUCK = 4'(DUCKS_PER_ROUND - 1);
  localparam logic [3:0] PASS = 4'(PASS_HITS);
  localparam logic [1:0] SHOTS = 2'(SHOTS_PER_DUCK);
  localparam logic [6:0] MAX_R = 7'(MAX_ROUND);
`ifdef FLYAWAY_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_FRAMES - 1);
`endif
  typedef enum logic [2:0] {IDLE, LAUNCH, FLY, FALL, ESCAPE, TALLY, OVER} fsm_t;
  fsm_t fsm, fsm_n;
  logic [1:0] shots_n;
  logic [3:0] hits_n, idx_n;
  logic [6:0] round_n;
  logic [CW-1:0] cnt, cnt_n;
  logic clear_n;
  always_ff @(posedge CLK) begin
    if (RESET || state == 2'b00) begin
      fsm <= IDLE;
      shots_left <= '0;
      hits_in_round <= '0;
      duck_index <= '0;
      round_num <= '0;
      cnt <= '0;
      round_clear <= 1'b0;
    end else if (state != 2'b10) begin
      fsm <= fsm_n;
      shots_left <= shots_n;
      hits_in_round <= hits_n;
      duck_index <= idx_n;
      round_num <= round_n;
      cnt <= cnt_n;
      round_clear <= clear_n;
    end
  end
  always_comb begin
    fsm_n = fsm;
    shots_n = shots_left;
    hits_n = hits_in_round;
    idx_n = duck_index;
    round_n = round_num;
    cnt_n = cnt;
    clear_n = 1'b0;
    case (fsm)
      IDLE: if (state == 2'b01) begin
        fsm_n = LAUNCH;
        round_n = 7'd1;
        idx_n = '0;
        hits_n = '0;
      end
      LAUNCH: begin
        fsm_n = FLY;
        shots_n = SHOTS;
        cnt_n = '0;
      end
      FLY: begin
`ifdef FLYAWAY_TIMEOUT_EN
        if (frame_tick) cnt_n = cnt + 1'b1;
`endif
        if (trigger) begin
          shots_n = shots_left - 2'd1;
          if (hit) begin
            hits_n = hits_in_round + 4'd1;
            fsm_n = FALL;
          end else if (shots_left == 2'd1) fsm_n = ESCAPE;
        end
`ifdef FLYAWAY_TIMEOUT_EN
        else if (frame_tick && cnt >= TO_LAST) fsm_n = ESCAPE;
`endif
        if (fsm_n != FLY) cnt_n = '0;
      end
      FALL, ESCAPE: if (frame_tick) begin
        cnt_n = cnt == FALL_LAST ? '0 : cnt + 1'b1;
        if (cnt == FALL_LAST) begin
          fsm_n = duck_index == LAST_DUCK ? TALLY : LAUNCH;
          idx_n = duck_index == LAST_DUCK ? duck_index : duck_index + 4'd1;
        end
      end
      TALLY: if (hits_in_round >= PASS) begin
        fsm_n = LAUNCH;
        clear_n = 1'b1;
        round_n = round_num >= MAX_R ? MAX_R : round_num + 7'd1;
        idx_n = '0;
        hits_n = '0;
      end else fsm_n = OVER;
      OVER: ;
      default: fsm_n = IDLE;
    endcase
  end
  assign duck_launch = fsm == LAUNCH;
  assign duck_active = fsm == FLY;
  assign duck_falling = fsm == FALL;
  assign duck_flyaway = fsm == ESCAPE;
  assign game_over = fsm == OVER;
endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: randomized and directed stimulus checked against a behavioural game model.
module tb_round_sequencer;
  localparam int DUCKS = 10, SHOTS = 3, PASS = 6, FALLF = 60, TOF = 300, MAXR = 99;
`ifdef FLYAWAY_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic CLK = 1'b0, RESET = 1'b1, frame_tick = 1'b0, trigger = 1'b0, hit = 1'b0;
  logic [1:0] state = 2'b00;
  logic duck_launch, duck_active, duck_falling, duck_flyaway, round_clear, game_over;
  logic [1:0] shots_left;
  logic [3:0] hits_in_round, duck_index;
  logic [6:0] round_num;
  int checks = 0, failures = 0;

  round_sequencer dut (
    .CLK(CLK), .RESET(RESET), .state(state), .frame_tick(frame_tick), .trigger(trigger), .hit(hit),
    .duck_launch(duck_launch), .duck_active(duck_active), .duck_falling(duck_falling),
    .duck_flyaway(duck_flyaway), .shots_left(shots_left), .hits_in_round(hits_in_round),
    .duck_index(duck_index), .round_num(round_num), .round_clear(round_clear), .game_over(game_over)
  );

  always #5 CLK = ~CLK;

  // Game model: what the player would see, tracked as a phase plus remaining fall ticks.
  typedef enum {M_IDLE, M_LAUNCH, M_FLY, M_FALL, M_ESC, M_TALLY, M_OVER} phase_t;
  phase_t ph = M_IDLE;
  int e_shots = 0, e_hits = 0, e_idx = 0, e_round = 0, left = 0, fly_ticks = 0;
  bit e_clear = 1'b0;

  always @(posedge CLK) begin
    if (RESET || state == 2'b00) begin
      ph = M_IDLE; e_shots = 0; e_hits = 0; e_idx = 0; e_round = 0; e_clear = 0;
    end else if (state != 2'b10 && ph != M_OVER) begin
      e_clear = 0;
      case (ph)
        M_IDLE: if (state == 2'b01) begin ph = M_LAUNCH; e_round = 1; e_idx = 0; e_hits = 0; end
        M_LAUNCH: begin ph = M_FLY; e_shots = SHOTS; fly_ticks = 0; end
        M_FLY: begin
          if (frame_tick) fly_ticks++;
          if (trigger) begin
            e_shots--;
            if (hit) begin e_hits++; ph = M_FALL; left = FALLF; end
            else if (e_shots == 0) begin ph = M_ESC; left = FALLF; end
          end else if (TO_EN && frame_tick && fly_ticks >= TOF) begin ph = M_ESC; left = FALLF; end
        end
        M_FALL, M_ESC: if (frame_tick && --left == 0) begin
          if (e_idx == DUCKS - 1) ph = M_TALLY;
          else begin e_idx++; ph = M_LAUNCH; end
        end
        M_TALLY: if (e_hits >= PASS) begin
          e_clear = 1; e_round = e_round >= MAXR ? MAXR : e_round + 1; e_idx = 0; e_hits = 0; ph = M_LAUNCH;
        end else ph = M_OVER;
        default: ;
      endcase
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", n, a, e, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("duck_launch", 32'(duck_launch), 32'(ph == M_LAUNCH));
    chk("duck_active", 32'(duck_active), 32'(ph == M_FLY));
    chk("duck_falling", 32'(duck_falling), 32'(ph == M_FALL));
    chk("duck_flyaway", 32'(duck_flyaway), 32'(ph == M_ESC));
    chk("game_over", 32'(game_over), 32'(ph == M_OVER));
    chk("round_clear", 32'(round_clear), 32'(e_clear));
    chk("shots_left", 32'(shots_left), e_shots);
    chk("hits_in_round", 32'(hits_in_round), e_hits);
    chk("duck_index", 32'(duck_index), e_idx);
    chk("round_num", 32'(round_num), e_round);
  end

  task automatic cyc(input logic t, input logic h, input logic f);
    trigger = t; hit = h; frame_tick = f;
    @(negedge CLK);
    trigger = 1'b0; hit = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic idle_cyc();
    cyc(!duck_active && $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic play_duck(input bit h);
    int n = 0;
    int m;
    while (!duck_active && n < 1000) begin idle_cyc(); n++; end
    chk("wait_duck_active", 32'(n < 1000), 1);
    m = h ? $urandom_range(0, SHOTS - 1) : SHOTS;
    for (int i = 0; i < m; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (i < SHOTS - 1) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end
    if (h) cyc(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    int n;
    int r;
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    chk("reset_round", 32'(round_num), 0);
    chk("reset_shots", 32'(shots_left), 0);
    RESET = 1'b0; state = 2'b01;
    cyc(1'b0, 1'b0, 1'b0);
    chk("t1_launch", 32'(duck_launch), 1);
    chk("t1_round", 32'(round_num), 1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t1_shots", 32'(shots_left), 3);
    chk("t1_active", 32'(duck_active), 1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t2_shots", 32'(shots_left), 2);
    chk("t2_hits", 32'(hits_in_round), 1);
    chk("t2_falling", 32'(duck_falling), 1);
    cyc(1'b1, 1'b1, 1'b0);
    chk("t6_fall_ignore", 32'(hits_in_round), 1);
    repeat (FALLF) cyc(1'b0, 1'b0, 1'b1);
    chk("t2_index", 32'(duck_index), 1);
    chk("t2_relaunch", 32'(duck_launch), 1);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("t3_shots", 32'(shots_left), 32'(2 - i));
    end
    chk("t3_flyaway", 32'(duck_flyaway), 1);
    chk("t3_hits", 32'(hits_in_round), 1);
    repeat (5) cyc(1'b0, 1'b0, 1'b1);
    RESET = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("t6_reset_round", 32'(round_num), 0);
    chk("t6_reset_flyaway", 32'(duck_flyaway), 0);
    RESET = 1'b0;
    for (int i = 0; i < DUCKS; i++) play_duck(i < 6);
    n = 0;
    while (!round_clear && n < 2000) begin idle_cyc(); n++; end
    chk("t4_wait_clear", 32'(n < 2000), 1);
    chk("t4_round2", 32'(round_num), 2);
    chk("t4_hits0", 32'(hits_in_round), 0);
    chk("t4_idx0", 32'(duck_index), 0);
    for (int i = 0; i < DUCKS; i++) play_duck(i < 5);
    n = 0;
    while (!game_over && n < 2000) begin idle_cyc(); n++; end
    chk("t4_wait_over", 32'(n < 2000), 1);
    repeat (1000) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("t4_over_held", 32'(game_over), 1);
    chk("t4_over_hits", 32'(hits_in_round), 5);
    chk("t4_over_idx", 32'(duck_index), 9);
    state = 2'b00;
    cyc(1'b0, 1'b0, 1'b0);
    chk("t4_clear_over", 32'(game_over), 0);
    chk("t4_clear_round", 32'(round_num), 0);
    state = 2'b01;
    for (int i = 0; i < 6000; i++) begin
      r = $urandom_range(0, 999);
      state = r < 30 ? 2'b10 : (r == 999 ? 2'b00 : 2'b01);
      RESET = $urandom_range(0, 1499) == 0;
      cyc($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    RESET = 1'b0; state = 2'b00;
    cyc(1'b0, 1'b0, 1'b0);
    state = 2'b01;
    n = 0;
    while (!duck_active && n < 10) begin cyc(1'b0, 1'b0, 1'b0); n++; end
    chk("t5_wait_active", 32'(duck_active), 1);
`ifdef FLYAWAY_TIMEOUT_EN
    repeat (TOF - 1) cyc(1'b0, 1'b0, 1'b1);
    chk("t5_before_timeout", 32'(duck_active), 1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("t5_timeout_flyaway", 32'(duck_flyaway), 1);
    chk("t5_timeout_shots", 32'(shots_left), 3);
    n = 0;
    while (!duck_active && n < 500) begin cyc(1'b0, 1'b0, 1'b1); n++; end
    chk("t5_wait_next", 32'(duck_active), 1);
    repeat (TOF - 1) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("t5_hit_wins", 32'(duck_falling), 1);
`else
    repeat (1000) cyc(1'b0, 1'b0, 1'b1);
    chk("t5_no_timeout", 32'(duck_active), 1);
    chk("t5_no_timeout_shots", 32'(shots_left), 3);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
